mux2: RTL and testbench

Two-input, one-bit selector with a registered output. It passes `in[0]` or `in[1]` to `out` under control of `sel`. It is a leaf primitive for control and datapath steering wherever a single bit must be chosen between two sources. The output is clocked so that it is glitch-free, and it has a defined value out of reset.

---
 rtl/mux2.sv | 50 +++++
 tb/tb_mux2.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux2.sv
// Two-source selector with an optional output register. X/Z on sel propagates
// as X rather than resolving to either source.
module mux2 #(
    parameter int DATA_W  = 1,
    parameter int OUT_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*DATA_W-1:0]   in,
    input  logic                  sel,
    output logic [DATA_W-1:0]     out
);

    logic [DATA_W-1:0] src0;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] out_d;

    assign src0 = in[DATA_W-1:0];
    assign src1 = in[2*DATA_W-1:DATA_W];

    // A case (not ?:) so an unknown sel drives X instead of merging equal bits.
    always_comb begin
        out_d = '0;
        case (sel)
            1'b0:    out_d = src0;
            1'b1:    out_d = src1;
            default: out_d = 'x;
        endcase
    end

    if (OUT_REG != 0) begin : g_reg
        logic [DATA_W-1:0] out_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign out = out_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = &{1'b0, clk, rst};
        assign out            = out_d;
    end

endmodule

// File: tb/tb_mux2.sv
// Bench for mux2: table-driven registered-mode vectors through a scoreboard
// queue, a latency/combinational hand sequence, and a wider-data instance.
module tb_mux2;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       sel;
    logic       out_r;
    logic       out_c;
    logic [7:0] in_w;
    logic       sel_w;
    logic [3:0] out_w;

    int cmp_cnt;
    int mis_cnt;

    logic [3:0] exp_q[$];
    logic [3:0] exp_w_q[$];

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] in;
        logic       sel;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    mux2 #(.DATA_W(1), .OUT_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .sel (sel),
        .out (out_r)
    );

    mux2 #(.DATA_W(1), .OUT_REG(0)) dut_comb (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .sel (sel),
        .out (out_c)
    );

    mux2 #(.DATA_W(4), .OUT_REG(1)) dut_wide (
        .clk (clk),
        .rst (rst),
        .in  (in_w),
        .sel (sel_w),
        .out (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input string nm, input logic [3:0] act);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            cmp_cnt++;
            mis_cnt++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", nm, act);
        end else begin
            e = exp_q.pop_front();
            check(nm, act, e);
        end
    endtask

    task automatic add(input string nm, input logic r, input logic [1:0] i,
                       input logic s, input logic e);
        vec_t v;
        v.name = nm; v.rst = r; v.in = i; v.sel = s; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        cmp_cnt = 0;
        mis_cnt = 0;
        rst   = 1'b1;
        in    = 2'b00;
        sel   = 1'b0;
        in_w  = 8'h00;
        sel_w = 1'b0;

        add("rst_hold0",   1'b1, 2'b11, 1'b1, 1'b0);
        add("rst_hold1",   1'b1, 2'b11, 1'b1, 1'b0);
        add("rst_hold2",   1'b1, 2'b10, 1'b0, 1'b0);
        add("rst_release", 1'b0, 2'b11, 1'b1, 1'b1);
        add("s1_in01",     1'b0, 2'b01, 1'b1, 1'b0);
        add("s1_in10",     1'b0, 2'b10, 1'b1, 1'b1);
        add("s0_in10",     1'b0, 2'b10, 1'b0, 1'b0);
        add("s0_in01",     1'b0, 2'b01, 1'b0, 1'b1);
        add("s1_in11",     1'b0, 2'b11, 1'b1, 1'b1);
        add("s0_in11",     1'b0, 2'b11, 1'b0, 1'b1);
        add("s1_in00",     1'b0, 2'b00, 1'b1, 1'b0);
        add("s0_in00",     1'b0, 2'b00, 1'b0, 1'b0);
        add("mid_run",     1'b0, 2'b10, 1'b1, 1'b1);
        add("mid_rst",     1'b1, 2'b10, 1'b1, 1'b0);
        add("mid_resume",  1'b0, 2'b10, 1'b1, 1'b1);
        add("same_cyc_chg",1'b0, 2'b01, 1'b0, 1'b1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].rst;
            in  = vecs[k].in;
            sel = vecs[k].sel;
            exp_q.push_back({3'b000, vecs[k].exp});
            @(posedge clk);
            #1;
            pop_check(vecs[k].name, {3'b000, out_r});
        end

        // Between-edge sel toggle: registered output holds, combinational follows.
        @(negedge clk);
        rst = 1'b0;
        in  = 2'b10;
        sel = 1'b0;
        @(posedge clk);
        #1;
        check("lat_pre_reg",  {3'b000, out_r}, 4'h0);
        check("lat_pre_comb", {3'b000, out_c}, 4'h0);
        #1;
        sel = 1'b1;
        #1;
        check("lat_hold_reg", {3'b000, out_r}, 4'h0);
        check("lat_comb_imm", {3'b000, out_c}, 4'h1);
        in = 2'b01;
        #1;
        check("glitch_hold_reg", {3'b000, out_r}, 4'h0);
        check("comb_follow_in",  {3'b000, out_c}, 4'h0);
        in = 2'b10;
        @(posedge clk);
        #1;
        check("lat_after_edge", {3'b000, out_r}, 4'h1);

        // Wider data: both nibble slices must come through intact.
        for (int k = 0; k < 12; k++) begin
            logic [7:0] iv;
            logic       sv;
            iv = 8'($urandom);
            sv = 1'($urandom_range(0, 1));
            if (k == 0) begin iv = 8'hA5; sv = 1'b0; end
            if (k == 1) begin iv = 8'hA5; sv = 1'b1; end
            @(negedge clk);
            in_w  = iv;
            sel_w = sv;
            exp_w_q.push_back(sv ? iv[7:4] : iv[3:0]);
            @(posedge clk);
            #1;
            if (exp_w_q.size() == 0) begin
                cmp_cnt++;
                mis_cnt++;
                $display("FAIL wide_%0d: scoreboard empty, got %h", k, out_w);
            end else begin
                check($sformatf("wide_%0d", k), out_w, exp_w_q.pop_front());
            end
        end

        @(negedge clk);
        rst = 1'b1;
        in_w = 8'hFF;
        sel_w = 1'b1;
        @(posedge clk);
        #1;
        check("wide_rst", out_w, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
